mult_seq_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `mult_seq_32x32` sequential multiplier among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, drives the multiplier's `st`/`mplier`/`mcand`, holds the operands for the whole run, captures `product` on `done`, and returns it to the granting requester with its own valid/ready handshake. It sits between the client ports and the multiplier instance and is the only driver of the multiplier inputs.

---
 rtl/mult_seq_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mult_seq_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential 32x32 multiplier among NREQ requesters.
// Grants one request at a time, runs the multiplier and returns the product (or a timeout abort).
module mult_seq_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 96,
  localparam int unsigned IdW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [32*NREQ-1:0]   req_mplier_i,
  input  logic [32*NREQ-1:0]   req_mcand_i,
  output logic [NREQ-1:0]      resp_valid_o,
  input  logic [NREQ-1:0]      resp_ready_i,
  output logic [63:0]          resp_product_o,
  output logic                 resp_err_o,
  output logic                 mul_st_o,
  output logic [31:0]          mul_mplier_o,
  output logic [31:0]          mul_mcand_o,
  input  logic                 mul_done_i,
  input  logic [63:0]          mul_product_i,
  output logic                 busy_o,
  output logic [IdW-1:0]       grant_id_o,
  output logic                 timeout_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StFlush, StIdle, StStart, StWait, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdW-1:0]    rr_ptr_q;
  logic [IdW-1:0]    grant_q;
  logic [31:0]       op_mplier_q, op_mcand_q;
  logic [63:0]       prod_q;
  logic              err_q, to_err_q, busy_q, mul_st_q;
  logic [NREQ-1:0]   resp_valid_q;

  logic              win_found;
  logic [IdW-1:0]    win_id;
  logic [IdW-1:0]    idx;
  logic [31:0]       win_mplier, win_mcand;

  // First valid request at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IdW'((32'(rr_ptr_q) + k) % NREQ);
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    win_mplier = '0;
    win_mcand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IdW'(i) == win_id) begin
        win_mplier = req_mplier_i[32*i +: 32];
        win_mcand  = req_mcand_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && win_found) req_ready_o[win_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFlush;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      op_mplier_q  <= '0;
      op_mcand_q   <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
      to_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      mul_st_q     <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      mul_st_q <= 1'b0;
      busy_q   <= 1'b1;
      case (state_q)
        // The multiplier has no reset; wait out any run left over from before.
        StFlush: begin
          if (mul_done_i || cnt_q == CntMax) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIdle: begin
          busy_q <= win_found;
          if (win_found) begin
            op_mplier_q <= win_mplier;
            op_mcand_q  <= win_mcand;
            grant_q     <= win_id;
            mul_st_q    <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (mul_done_i) begin
            prod_q       <= mul_product_i;
            err_q        <= 1'b0;
            resp_valid_q <= NREQ'(1) << grant_q;
            state_q      <= StResp;
          end else if (cnt_q == CntMax) begin
            prod_q       <= '0;
            err_q        <= 1'b1;
            to_err_q     <= 1'b1;
            resp_valid_q <= NREQ'(1) << grant_q;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_ready_i[grant_q]) begin
            resp_valid_q <= '0;
            rr_ptr_q     <= (grant_q == IdW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            cnt_q        <= '0;
            if (err_q) begin
              state_q <= StFlush;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StFlush;
      endcase
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_product_o = prod_q;
  assign resp_err_o     = err_q;
  assign mul_st_o       = mul_st_q;
  assign mul_mplier_o   = op_mplier_q;
  assign mul_mcand_o    = op_mcand_q;
  assign busy_o         = busy_q;
  assign grant_id_o     = grant_q;
  assign timeout_err_o  = to_err_q;

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Directed bench for mult_seq_arbiter with a behavioural stand-in for the sequential multiplier.
module tb_mult_seq_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [127:0] req_mplier, req_mcand;
  logic [63:0]  resp_product, mul_product;
  logic         resp_err, mul_st, mul_done, busy, timeout_err;
  logic [31:0]  mul_mplier, mul_mcand;
  logic [1:0]   grant_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_seq_arbiter #(.NREQ(4), .TIMEOUT(96)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_mplier_i   (req_mplier),
    .req_mcand_i    (req_mcand),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_product_o (resp_product),
    .resp_err_o     (resp_err),
    .mul_st_o       (mul_st),
    .mul_mplier_o   (mul_mplier),
    .mul_mcand_o    (mul_mcand),
    .mul_done_i     (mul_done),
    .mul_product_i  (mul_product),
    .busy_o         (busy),
    .grant_id_o     (grant_id),
    .timeout_err_o  (timeout_err)
  );

  // Multiplier stand-in: no reset, done 33 + popcount(mplier) cycles after the st edge.
  logic        m_busy = 1'b0;
  logic        m_done_raw = 1'b0;
  logic [63:0] m_prod = '0;
  int          m_rem = 0;
  logic        kill = 1'b0;

  always @(posedge clk) begin
    m_done_raw <= 1'b0;
    if (mul_st) begin
      m_busy <= 1'b1;
      m_rem  <= 32 + $countones(mul_mplier);
      m_prod <= {32'b0, mul_mplier} * {32'b0, mul_mcand};
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done_raw <= 1'b1;
        m_busy     <= 1'b0;
      end
    end
  end

  assign mul_done    = m_done_raw & ~kill;
  assign mul_product = m_prod;

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    bit st_seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mul_st, resp_err, timeout_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {busy, mul_st, resp_err, timeout_err});
    end
    checks++;
    if ({req_ready, resp_valid, grant_id} !== 10'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b required 0", {req_ready, resp_valid, grant_id});
    end
    checks++;
    if ({resp_product, mul_mplier, mul_mcand} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {resp_product, mul_mplier, mul_mcand});
    end
    rst_n = 1'b1;
    n = 0;
    st_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (mul_st) st_seen = 1'b1;
      if (!busy) break;
    end
    checks++;
    if (n !== 96) begin
      errors++;
      $display("FAIL flush_len: got %0d required 96", n);
    end
    checks++;
    if (st_seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_st: got %b required 0", st_seen);
    end
  endtask

  task automatic test_single();
    bit ok;
    req_mplier[31:0] = 32'd3;
    req_mcand[31:0]  = 32'd5;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    #1;
    checks++;
    if ({mul_st, req_ready, grant_id, mul_mplier, mul_mcand} !==
        {1'b1, 4'b0, 2'd0, 32'd3, 32'd5}) begin
      errors++;
      $display("FAIL single_start: got st=%b rdy=%b gid=%0d a=%h b=%h required st=1 rdy=0000 gid=0 a=3 b=5",
               mul_st, req_ready, grant_id, mul_mplier, mul_mcand);
    end
    @(negedge clk);
    checks++;
    if (mul_st !== 1'b0) begin
      errors++;
      $display("FAIL single_st_pulse: got %b required 0", mul_st);
    end
    wait_resp(ok);
    checks++;
    if (!ok || resp_valid !== 4'b0001 || resp_product !== 64'hF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got v=%b p=%h e=%b required v=0001 p=f e=0",
               resp_valid, resp_product, resp_err);
    end
    resp_ready = 4'b0001;
    @(negedge clk);
    resp_ready = 4'b0;
    checks++;
    if (resp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got v=%b busy=%b required v=0000 busy=0", resp_valid, busy);
    end
  endtask

  task automatic test_max();
    int n;
    req_mplier[127:96] = 32'hFFFF_FFFF;
    req_mcand[127:96]  = 32'hFFFF_FFFF;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL max_ready: got %b required 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid != 4'b0) break;
    end
    checks++;
    if (n !== 66) begin
      errors++;
      $display("FAIL max_latency: got %0d required 66", n);
    end
    checks++;
    if (resp_valid !== 4'b1000 || resp_product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_resp: got v=%b p=%h required v=1000 p=fffffffe00000001",
               resp_valid, resp_product);
    end
    resp_ready = 4'b1000;
    @(negedge clk);
    resp_ready = 4'b0;
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_prod [4];
    int exp_id;
    bit ok;
    exp_prod = '{64'h20, 64'h33, 64'h48, 64'h5F};
    for (int i = 0; i < 4; i++) begin
      req_mplier[32*i +: 32] = 32'(i + 2);
      req_mcand[32*i +: 32]  = 32'(16 + i);
    end
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      #1;
      for (int i = 0; i < 300; i++) begin
        if (req_ready != 4'b0) break;
        @(negedge clk);
        #1;
      end
      checks++;
      if (req_ready !== 4'(1 << exp_id)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b required %b", g, req_ready, 4'(1 << exp_id));
      end
      @(negedge clk);
      if (g == 4) req_valid = 4'b0;
      wait_resp(ok);
      checks++;
      if (!ok || resp_valid !== 4'(1 << exp_id) || resp_product !== exp_prod[exp_id]) begin
        errors++;
        $display("FAIL rr_resp%0d: got v=%b p=%h required v=%b p=%h",
                 g, resp_valid, resp_product, 4'(1 << exp_id), exp_prod[exp_id]);
      end
      @(negedge clk);
    end
    resp_ready = 4'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    req_mplier[63:32] = 32'd6;
    req_mcand[63:32]  = 32'd7;
    req_mplier[95:64] = 32'd8;
    req_mcand[95:64]  = 32'd9;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_ready: got %b required 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    wait_resp(ok);
    checks++;
    if (!ok || resp_product !== 64'h2A) begin
      errors++;
      $display("FAIL bp_resp: got p=%h required 2a", resp_product);
    end
    // Every ready bit except the owner's must be ignored.
    resp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0010 || resp_product !== 64'h2A || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b p=%h rdy=%b required v=0010 p=2a rdy=0000",
                 i, resp_valid, resp_product, req_ready);
      end
    end
    resp_ready = 4'b0010;
    @(negedge clk);
    resp_ready = 4'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || resp_valid !== 4'b0) begin
      errors++;
      $display("FAIL bp_next_grant: got rdy=%b v=%b required rdy=0100 v=0000", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 4'b0;
    wait_resp(ok);
    checks++;
    if (!ok || resp_valid !== 4'b0100 || resp_product !== 64'h48) begin
      errors++;
      $display("FAIL bp_resp2: got v=%b p=%h required v=0100 p=48", resp_valid, resp_product);
    end
    resp_ready = 4'b0100;
    @(negedge clk);
    resp_ready = 4'b0;
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    kill = 1'b1;
    req_mplier[127:96] = 32'h1234;
    req_mcand[127:96]  = 32'h10;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL to_ready: got %b required 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid != 4'b0) break;
    end
    checks++;
    if (n !== 97) begin
      errors++;
      $display("FAIL to_latency: got %0d required 97", n);
    end
    checks++;
    if (resp_valid !== 4'b1000 || resp_err !== 1'b1 || resp_product !== 64'h0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_resp: got v=%b e=%b p=%h te=%b required v=1000 e=1 p=0 te=1",
               resp_valid, resp_err, resp_product, timeout_err);
    end
    resp_ready = 4'b1000;
    @(negedge clk);
    resp_ready = 4'b0;
    checks++;
    if (resp_valid !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_flush_entry: got v=%b busy=%b required v=0000 busy=1", resp_valid, busy);
    end
    n = 1;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 97) begin
      errors++;
      $display("FAIL to_flush_len: got %0d required 97", n);
    end
    kill = 1'b0;
    req_mplier[31:0] = 32'd7;
    req_mcand[31:0]  = 32'h100;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0;
    wait_resp(ok);
    checks++;
    if (!ok || resp_valid !== 4'b0001 || resp_product !== 64'h700 || resp_err !== 1'b0 ||
        timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_recover: got v=%b p=%h e=%b te=%b required v=0001 p=700 e=0 te=1",
               resp_valid, resp_product, resp_err, timeout_err);
    end
    resp_ready = 4'b0001;
    @(negedge clk);
    resp_ready = 4'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    req_mplier[63:32] = 32'hFFFF_FFFF;
    req_mcand[63:32]  = 32'd2;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mul_st, timeout_err, grant_id, resp_valid} !== 9'b0 || mul_mcand !== 32'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b st=%b te=%b gid=%0d v=%b b=%h required all 0",
               busy, mul_st, timeout_err, grant_id, resp_valid, mul_mcand);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_mplier[31:0] = 32'd3;
    req_mcand[31:0]  = 32'd3;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL midrst_no_early_grant: got %b required 0000", req_ready);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_grant: got %b required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    wait_resp(ok);
    checks++;
    if (!ok || resp_valid !== 4'b0001 || resp_product !== 64'h9) begin
      errors++;
      $display("FAIL midrst_resp: got v=%b p=%h required v=0001 p=9", resp_valid, resp_product);
    end
    resp_ready = 4'b0001;
    @(negedge clk);
    resp_ready = 4'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b0;
    resp_ready = 4'b0;
    req_mplier = '0;
    req_mcand  = '0;
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
